// File: rtl/zvs_deadtime_gen_if.sv
// Gate-driver control bundle between the PWM generator side and the ZVS dead-time generator.
// master drives the control inputs and observes gates; slave is the dead-time generator.
interface zvs_deadtime_gen_if #(
  parameter int unsigned DT_WIDTH = 8
);
  logic                ENABLE;
  logic                PWM_IN;
  logic [DT_WIDTH-1:0] DT_MAX_LH;
  logic [DT_WIDTH-1:0] DT_MAX_HL;
  logic                ZVS_HI;
  logic                ZVS_LO;
  logic                FAULT_IN;
  logic                FAULT_CLR;
  logic                GATE_HI;
  logic                GATE_LO;
  logic                HARD_SW;
  logic [2:0]          STATE;

  modport master (
    output ENABLE, PWM_IN, DT_MAX_LH, DT_MAX_HL, ZVS_HI, ZVS_LO, FAULT_IN, FAULT_CLR,
    input  GATE_HI, GATE_LO, HARD_SW, STATE
  );

  modport slave (
    input  ENABLE, PWM_IN, DT_MAX_LH, DT_MAX_HL, ZVS_HI, ZVS_LO, FAULT_IN, FAULT_CLR,
    output GATE_HI, GATE_LO, HARD_SW, STATE
  );
endinterface

// File: rtl/zvs_deadtime_gen.sv
// Complementary half-bridge gate drive from a single PWM, with dead time on every edge,
// optional ZVS early exit, fault trip and enable gating.
module zvs_deadtime_gen #(
  parameter int unsigned DT_WIDTH = 8,
  parameter int unsigned MIN_DT   = 4,
  parameter bit          ZVS_EN   = 1'b1
) (
  input  logic              CLK,
  input  logic              reset_n,
  zvs_deadtime_gen_if.slave bus
);

  localparam int unsigned          CNT_W    = DT_WIDTH + 1;
  localparam logic [DT_WIDTH-1:0]  MIN_DT_W = DT_WIDTH'(MIN_DT);

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_LO_ON = 3'd1,
    ST_DT_LH = 3'd2,
    ST_HI_ON = 3'd3,
    ST_DT_HL = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DT_WIDTH-1:0] cnt;
  logic [DT_WIDTH-1:0] cnt_nxt;
  logic                hard_sw_nxt;
  logic                gate_hi;
  logic                gate_lo;
  logic                hard_sw;

  logic [1:0]          zvs_hi_sync;
  logic [1:0]          zvs_lo_sync;
  logic [1:0]          fault_sync;
  logic                zvs_hi_s;
  logic                zvs_lo_s;
  logic                fault_s;

  logic [DT_WIDTH-1:0] nmax_lh;
  logic [DT_WIDTH-1:0] nmax_hl;
  logic [CNT_W-1:0]    cnt_done;
  logic                min_met;
  logic                lh_timeout;
  logic                hl_timeout;
  logic                lh_zvs;
  logic                hl_zvs;
  logic                off_now;
  logic                off_nxt;

  // Two-flop synchronisers for the asynchronous comparator and trip inputs
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      zvs_hi_sync <= '0;
      zvs_lo_sync <= '0;
      fault_sync  <= '0;
    end else begin
      zvs_hi_sync <= {zvs_hi_sync[0], bus.ZVS_HI};
      zvs_lo_sync <= {zvs_lo_sync[0], bus.ZVS_LO};
      fault_sync  <= {fault_sync[0], bus.FAULT_IN};
    end
  end

  assign zvs_hi_s = zvs_hi_sync[1];
  assign zvs_lo_s = zvs_lo_sync[1];
  assign fault_s  = fault_sync[1];

  // cnt_done counts the both-off cycle that completes at the coming edge
  assign nmax_lh    = (bus.DT_MAX_LH > MIN_DT_W) ? bus.DT_MAX_LH : MIN_DT_W;
  assign nmax_hl    = (bus.DT_MAX_HL > MIN_DT_W) ? bus.DT_MAX_HL : MIN_DT_W;
  assign cnt_done   = CNT_W'(cnt) + CNT_W'(1);
  assign min_met    = cnt_done >= CNT_W'(MIN_DT_W);
  assign lh_timeout = cnt_done >= CNT_W'(nmax_lh);
  assign hl_timeout = cnt_done >= CNT_W'(nmax_hl);
  assign lh_zvs     = ZVS_EN && min_met && zvs_hi_s;
  assign hl_zvs     = ZVS_EN && min_met && zvs_lo_s;
  assign off_now    = (state != ST_LO_ON) && (state != ST_HI_ON);

  // Next-state: fault beats disable beats normal sequencing.
  // OFF waits for MIN_DT both-off cycles so a quick enable toggle or reset cannot shorten the dead time.
  always_comb begin
    state_nxt   = state;
    hard_sw_nxt = 1'b0;
    if (fault_s) begin
      state_nxt = ST_FAULT;
    end else if (state == ST_FAULT) begin
      if (bus.FAULT_CLR) state_nxt = ST_OFF;
    end else if (!bus.ENABLE) begin
      state_nxt = ST_OFF;
    end else begin
      case (state)
        ST_OFF: begin
          if (min_met) state_nxt = ST_LO_ON;
        end
        ST_LO_ON: begin
          if (bus.PWM_IN) state_nxt = ST_DT_LH;
        end
        ST_DT_LH: begin
          if (!bus.PWM_IN) begin
            state_nxt = ST_LO_ON;
          end else if (lh_zvs) begin
            state_nxt = ST_HI_ON;
          end else if (lh_timeout) begin
            state_nxt   = ST_HI_ON;
            hard_sw_nxt = ZVS_EN;
          end
        end
        ST_HI_ON: begin
          if (!bus.PWM_IN) state_nxt = ST_DT_HL;
        end
        ST_DT_HL: begin
          if (bus.PWM_IN) begin
            state_nxt = ST_HI_ON;
          end else if (hl_zvs) begin
            state_nxt = ST_LO_ON;
          end else if (hl_timeout) begin
            state_nxt   = ST_LO_ON;
            hard_sw_nxt = ZVS_EN;
          end
        end
        default: state_nxt = ST_OFF;
      endcase
    end

    off_nxt = (state_nxt != ST_LO_ON) && (state_nxt != ST_HI_ON);
    cnt_nxt = '0;
    if (off_now && off_nxt) begin
      cnt_nxt = (cnt == {DT_WIDTH{1'b1}}) ? cnt : cnt + DT_WIDTH'(1);
    end
  end

  // State, counter and gate registers; gates decode the state being entered
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_OFF;
      cnt     <= '0;
      gate_hi <= 1'b0;
      gate_lo <= 1'b0;
      hard_sw <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      gate_hi <= (state_nxt == ST_HI_ON);
      gate_lo <= (state_nxt == ST_LO_ON);
      hard_sw <= hard_sw_nxt;
    end
  end

  assign bus.GATE_HI = gate_hi;
  assign bus.GATE_LO = gate_lo;
  assign bus.HARD_SW = hard_sw;
  assign bus.STATE   = state;

endmodule

// File: tb/tb_zvs_deadtime_gen.sv
// Bench for zvs_deadtime_gen: directed gate-edge expectations checked by a monitor that
// measures the both-off run before each gate rise, plus invariant tracking.
module tb_zvs_deadtime_gen;

  localparam int unsigned DT_WIDTH = 8;
  localparam int          MIN_DT   = 4;

  logic CLK;
  logic reset_n;

  zvs_deadtime_gen_if #(.DT_WIDTH(DT_WIDTH)) if_main ();
  zvs_deadtime_gen_if #(.DT_WIDTH(DT_WIDTH)) if_fix ();

  zvs_deadtime_gen #(.DT_WIDTH(DT_WIDTH), .MIN_DT(MIN_DT), .ZVS_EN(1'b1)) u_dut (
    .CLK(CLK), .reset_n(reset_n), .bus(if_main)
  );

  zvs_deadtime_gen #(.DT_WIDTH(DT_WIDTH), .MIN_DT(MIN_DT), .ZVS_EN(1'b0)) u_fix (
    .CLK(CLK), .reset_n(reset_n), .bus(if_fix)
  );

  assign if_fix.ENABLE    = if_main.ENABLE;
  assign if_fix.PWM_IN    = if_main.PWM_IN;
  assign if_fix.DT_MAX_LH = if_main.DT_MAX_LH;
  assign if_fix.DT_MAX_HL = if_main.DT_MAX_HL;
  assign if_fix.ZVS_HI    = if_main.ZVS_HI;
  assign if_fix.ZVS_LO    = if_main.ZVS_LO;
  assign if_fix.FAULT_IN  = if_main.FAULT_IN;
  assign if_fix.FAULT_CLR = if_main.FAULT_CLR;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit hi;
    int dead;
    bit hard;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   sb_on = 1'b1;
  int   both_on = 0;
  int   short_dt = 0;
  int   stray_hard = 0;
  int   fix_both = 0;
  int   fix_hard = 0;
  int   rise_no = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input bit hi, input int dead, input bit hard);
    exp_t e;
    e.hi   = hi;
    e.dead = dead;
    e.hard = hard;
    exp_q.push_back(e);
  endtask

  // Monitor: measure both-off run before each gate rise and compare with the queue head
  int offrun = 0;
  bit prev_hi = 1'b0;
  bit prev_lo = 1'b0;
  bit have_last = 1'b0;
  bit last_hi = 1'b0;

  always @(negedge CLK) begin
    if (!reset_n) begin
      offrun    = 0;
      prev_hi   = 1'b0;
      prev_lo   = 1'b0;
      have_last = 1'b0;
    end else begin
      bit hi, lo, hard, rise_hi, rise_lo;
      hi      = if_main.GATE_HI;
      lo      = if_main.GATE_LO;
      hard    = if_main.HARD_SW;
      rise_hi = hi && !prev_hi;
      rise_lo = lo && !prev_lo;
      if (hi && lo) both_on++;
      if (rise_hi || rise_lo) begin
        if (have_last && (last_hi != rise_hi) && offrun < MIN_DT) short_dt++;
        if (sb_on) begin
          rise_no++;
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_rise#%0d: unexpected rise gate_hi=%0d dead=%0d hard=%0d", rise_no, rise_hi, offrun, hard);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.hi != rise_hi || (e.dead >= 0 && e.dead != offrun) || e.hard != hard) begin
              fails++;
              $display("FAIL sb_rise#%0d: got gate_hi=%0d dead=%0d hard=%0d expected gate_hi=%0d dead=%0d hard=%0d",
                       rise_no, rise_hi, offrun, hard, e.hi, e.dead, e.hard);
            end
          end
        end
        have_last = 1'b1;
        last_hi   = rise_hi;
        offrun    = 0;
      end else begin
        if (hard) stray_hard++;
        if (!hi && !lo) offrun++;
      end
      prev_hi = hi;
      prev_lo = lo;
    end
  end

  always @(negedge CLK) begin
    if (reset_n) begin
      if (if_fix.GATE_HI && if_fix.GATE_LO) fix_both++;
      if (if_fix.HARD_SW) fix_hard++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n            = 1'b0;
    if_main.ENABLE     = 1'b0;
    if_main.PWM_IN     = 1'b0;
    if_main.DT_MAX_LH  = 8'd10;
    if_main.DT_MAX_HL  = 8'd10;
    if_main.ZVS_HI     = 1'b0;
    if_main.ZVS_LO     = 1'b0;
    if_main.FAULT_IN   = 1'b0;
    if_main.FAULT_CLR  = 1'b0;
    tick(3);
    chk("reset_state", int'(if_main.STATE), 0);
    chk("reset_gate_hi", int'(if_main.GATE_HI), 0);
    chk("reset_gate_lo", int'(if_main.GATE_LO), 0);
    chk("reset_hard_sw", int'(if_main.HARD_SW), 0);

    // Enable: bootstrap charge via LO_ON
    reset_n        = 1'b1;
    if_main.ENABLE = 1'b1;
    push_exp(1'b0, -1, 1'b0);
    tick(6);
    chk("enable_lo_on", int'(if_main.STATE), 1);

    // Basic timing, fixed dead time of 10 (no ZVS feedback -> timeout)
    for (int i = 0; i < 2; i++) begin
      if_main.PWM_IN = 1'b1;
      push_exp(1'b1, 10, 1'b1);
      tick(1);
      if (i == 0) begin
        chk("lo_falls_next_edge", int'(if_main.GATE_LO), 0);
        chk("state_dt_lh", int'(if_main.STATE), 2);
      end
      tick(24);
      if_main.PWM_IN = 1'b0;
      push_exp(1'b0, 10, 1'b1);
      tick(25);
    end

    // ZVS early exit: comparator seen 3 cycles into dead time -> exit at 5
    if_main.DT_MAX_LH = 8'd20;
    if_main.PWM_IN    = 1'b1;
    push_exp(1'b1, 5, 1'b0);
    tick(3);
    if_main.ZVS_HI = 1'b1;
    tick(22);
    if_main.ZVS_HI = 1'b0;
    if_main.PWM_IN = 1'b0;
    push_exp(1'b0, 10, 1'b1);
    tick(25);

    // ZVS already present: MIN_DT floor applies on both edges
    if_main.ZVS_HI = 1'b1;
    if_main.PWM_IN = 1'b1;
    push_exp(1'b1, 4, 1'b0);
    tick(25);
    if_main.ZVS_HI    = 1'b0;
    if_main.ZVS_LO    = 1'b1;
    if_main.DT_MAX_HL = 8'd30;
    if_main.PWM_IN    = 1'b0;
    push_exp(1'b0, 4, 1'b0);
    tick(25);
    if_main.ZVS_LO = 1'b0;

    // Timeout with HARD_SW, and DT_MAX=0 clamped to MIN_DT
    if_main.DT_MAX_LH = 8'd12;
    if_main.PWM_IN    = 1'b1;
    push_exp(1'b1, 12, 1'b1);
    tick(25);
    if_main.DT_MAX_HL = 8'd0;
    if_main.PWM_IN    = 1'b0;
    push_exp(1'b0, 4, 1'b1);
    tick(25);
    if_main.DT_MAX_LH = 8'd0;
    if_main.PWM_IN    = 1'b1;
    push_exp(1'b1, 4, 1'b1);
    tick(25);
    if_main.DT_MAX_HL = 8'd10;
    if_main.PWM_IN    = 1'b0;
    push_exp(1'b0, 10, 1'b1);
    tick(25);

    // Glitch abort in DT_LH: GATE_LO re-enabled after 2 off cycles
    if_main.DT_MAX_LH = 8'd10;
    if_main.PWM_IN    = 1'b1;
    tick(2);
    if_main.PWM_IN = 1'b0;
    push_exp(1'b0, 2, 1'b0);
    tick(5);
    chk("abort_lh_state", int'(if_main.STATE), 1);
    chk("abort_lh_gate_hi", int'(if_main.GATE_HI), 0);

    // Abort in DT_HL back to HI_ON after 3 off cycles
    if_main.PWM_IN = 1'b1;
    push_exp(1'b1, 10, 1'b1);
    tick(25);
    if_main.PWM_IN = 1'b0;
    tick(3);
    if_main.PWM_IN = 1'b1;
    push_exp(1'b1, 3, 1'b0);
    tick(10);
    chk("abort_hl_state", int'(if_main.STATE), 3);

    // Fault while HI_ON: trip after the 2-flop sync, clear gated by fault state
    if_main.FAULT_IN = 1'b1;
    tick(2);
    chk("fault_sync_delay_hi", int'(if_main.GATE_HI), 1);
    tick(1);
    chk("fault_gate_hi", int'(if_main.GATE_HI), 0);
    chk("fault_gate_lo", int'(if_main.GATE_LO), 0);
    chk("fault_state", int'(if_main.STATE), 5);
    if_main.PWM_IN    = 1'b0;
    if_main.FAULT_CLR = 1'b1;
    tick(3);
    chk("fault_clr_ignored", int'(if_main.STATE), 5);
    if_main.FAULT_CLR = 1'b0;
    if_main.FAULT_IN  = 1'b0;
    tick(4);
    chk("fault_held_no_clr", int'(if_main.STATE), 5);
    push_exp(1'b0, -1, 1'b0);
    if_main.FAULT_CLR = 1'b1;
    tick(1);
    chk("fault_clr_off", int'(if_main.STATE), 0);
    tick(1);
    chk("fault_restart_lo_on", int'(if_main.STATE), 1);
    chk("fault_restart_gate_lo", int'(if_main.GATE_LO), 1);
    if_main.FAULT_CLR = 1'b0;
    tick(5);

    // ENABLE dropped during DT_HL
    if_main.PWM_IN = 1'b1;
    push_exp(1'b1, 10, 1'b1);
    tick(25);
    if_main.PWM_IN = 1'b0;
    tick(3);
    chk("dt_hl_state", int'(if_main.STATE), 4);
    if_main.ENABLE = 1'b0;
    tick(1);
    chk("disable_off", int'(if_main.STATE), 0);
    push_exp(1'b0, -1, 1'b0);
    if_main.ENABLE = 1'b1;
    tick(1);
    chk("reenable_lo_on", int'(if_main.STATE), 1);
    tick(5);

    // One-cycle enable drop from LO_ON: OFF holds until MIN_DT off cycles elapse
    if_main.ENABLE = 1'b0;
    tick(1);
    chk("toggle_off", int'(if_main.STATE), 0);
    if_main.ENABLE = 1'b1;
    push_exp(1'b0, 4, 1'b0);
    tick(1);
    chk("toggle_floor_hold", int'(if_main.STATE), 0);
    tick(4);
    chk("toggle_lo_on", int'(if_main.STATE), 1);

    // Asynchronous reset between edges while HI_ON
    if_main.PWM_IN = 1'b1;
    push_exp(1'b1, 10, 1'b1);
    tick(25);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_gate_hi", int'(if_main.GATE_HI), 0);
    chk("async_rst_gate_lo", int'(if_main.GATE_LO), 0);
    chk("async_rst_state", int'(if_main.STATE), 0);
    if_main.PWM_IN = 1'b0;
    push_exp(1'b0, -1, 1'b0);
    tick(2);
    reset_n = 1'b1;
    tick(6);
    chk("post_rst_lo_on", int'(if_main.STATE), 1);
    chk("queue_drained", exp_q.size(), 0);

    // Random PWM/DT/ZVS/ENABLE stress, invariants only
    sb_on = 1'b0;
    for (int i = 0; i < 250; i++) begin
      if_main.PWM_IN    = 1'($urandom_range(0, 1));
      if_main.DT_MAX_LH = 8'($urandom_range(0, 15));
      if_main.DT_MAX_HL = 8'($urandom_range(0, 15));
      if_main.ZVS_HI    = 1'($urandom_range(0, 1));
      if_main.ZVS_LO    = 1'($urandom_range(0, 1));
      if_main.ENABLE    = ($urandom_range(0, 15) != 0);
      tick(int'($urandom_range(1, 12)));
    end
    if_main.ENABLE = 1'b1;
    if_main.PWM_IN = 1'b0;
    tick(30);

    chk("never_both_on", both_on, 0);
    chk("min_dead_time", short_dt, 0);
    chk("hard_sw_single_pulse", stray_hard, 0);
    chk("fixed_never_both_on", fix_both, 0);
    chk("fixed_no_hard_sw", fix_hard, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
